// File: rtl/mult_hilo_unit.sv
// Radix-2 shift-add multiplier (MULTS/MULTU) owning the HI/LO registers and
// the execute-stage result mux.
module mult_hilo_unit #(
    parameter int unsigned WIDTH      = 32,
    parameter logic [4:0]  MULTS_CODE = 5'd2,
    parameter logic [4:0]  MULTU_CODE = 5'd3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [4:0]       op_sel,
    input  logic             hi_en,
    input  logic             lo_en,
    input  logic [1:0]       alu_lo_hi,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] alu_result,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out,
    output logic [WIDTH-1:0] result_out
);

    localparam int unsigned CntW = $clog2(WIDTH) + 1;
    localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

    typedef enum logic [1:0] {StIdle, StCalc, StWrite} state_e;

    state_e               state_q, state_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]     mcand_q, mcand_d;
    logic [WIDTH-1:0]     mplier_q, mplier_d;
    logic [CntW-1:0]      cnt_q, cnt_d;
    logic                 neg_q, neg_d;
    logic                 hi_en_q, hi_en_d;
    logic                 lo_en_q, lo_en_d;
    logic [WIDTH-1:0]     hi_q, hi_d;
    logic [WIDTH-1:0]     lo_q, lo_d;
    logic                 done_q, done_d;

    logic                 accept;
    logic                 is_signed;
    logic [WIDTH-1:0]     a_mag, b_mag;
    logic [WIDTH-1:0]     addend;
    logic [WIDTH:0]       sum;
    logic [2*WIDTH-1:0]   product;

    assign is_signed = (op_sel == MULTS_CODE);
    assign accept    = start && (is_signed || (op_sel == MULTU_CODE)) && (hi_en || lo_en);

    // The most negative value negates to itself, which is the correct unsigned magnitude.
    assign a_mag = (is_signed && a[WIDTH-1]) ? -a : a;
    assign b_mag = (is_signed && b[WIDTH-1]) ? -b : b;

    // Carry out of the upper half is kept in sum[WIDTH] and shifted back in.
    assign addend  = mplier_q[0] ? mcand_q : '0;
    assign sum     = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, addend};
    assign product = neg_q ? -acc_q : acc_q;

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        neg_d    = neg_q;
        hi_en_d  = hi_en_q;
        lo_en_d  = lo_en_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = 1'b0;

        case (state_q)
            StIdle: begin
                if (accept) begin
                    mcand_d  = a_mag;
                    mplier_d = b_mag;
                    neg_d    = is_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
                    hi_en_d  = hi_en;
                    lo_en_d  = lo_en;
                    acc_d    = '0;
                    cnt_d    = '0;
                    state_d  = StCalc;
                end
            end
            StCalc: begin
                acc_d    = {sum, acc_q[WIDTH-1:1]};
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == CntLast) begin
                    state_d = StWrite;
                end
            end
            StWrite: begin
                if (hi_en_q) hi_d = product[2*WIDTH-1:WIDTH];
                if (lo_en_q) lo_d = product[WIDTH-1:0];
                done_d  = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            neg_q    <= 1'b0;
            hi_en_q  <= 1'b0;
            lo_en_q  <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
            neg_q    <= neg_d;
            hi_en_q  <= hi_en_d;
            lo_en_q  <= lo_en_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            done_q   <= done_d;
        end
    end

    assign busy   = (state_q != StIdle);
    assign done   = done_q;
    assign hi_out = hi_q;
    assign lo_out = lo_q;

    always_comb begin
        case (alu_lo_hi)
            2'b10:   result_out = hi_q;
            2'b01:   result_out = lo_q;
            default: result_out = alu_result;
        endcase
    end

endmodule

// File: tb/tb_mult_hilo_unit.sv
// Self-checking bench for mult_hilo_unit: arithmetic reference model compared
// every cycle, plus directed literal expectations.
module tb_mult_hilo_unit;

    localparam logic [4:0] OpAdd   = 5'd0;
    localparam logic [4:0] OpMults = 5'd2;
    localparam logic [4:0] OpMultu = 5'd3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [4:0]  op_sel;
    logic        hi_en, lo_en;
    logic [1:0]  alu_lo_hi;
    logic [31:0] a, b, alu_result;
    logic        busy, done;
    logic [31:0] hi_out, lo_out, result_out;

    int n_cmp = 0;
    int n_err = 0;

    mult_hilo_unit #(
        .WIDTH(32),
        .MULTS_CODE(5'd2),
        .MULTU_CODE(5'd3)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .op_sel(op_sel),
        .hi_en(hi_en),
        .lo_en(lo_en),
        .alu_lo_hi(alu_lo_hi),
        .a(a),
        .b(b),
        .alu_result(alu_result),
        .busy(busy),
        .done(done),
        .hi_out(hi_out),
        .lo_out(lo_out),
        .result_out(result_out)
    );

    always #5 clk = ~clk;

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    // Reference model: remaining busy cycles, full-width product computed at accept.
    int          m_cnt;
    logic        m_done;
    logic [31:0] m_hi, m_lo;
    logic [63:0] m_prod;
    logic        m_he, m_le;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_cnt = 0; m_done = 0; m_hi = 0; m_lo = 0; m_prod = 0; m_he = 0; m_le = 0;
        end else begin
            m_done = 0;
            if (m_cnt > 0) begin
                m_cnt--;
                if (m_cnt == 0) begin
                    if (m_he) m_hi = m_prod[63:32];
                    if (m_le) m_lo = m_prod[31:0];
                    m_done = 1;
                end
            end else if (start && (op_sel == OpMults || op_sel == OpMultu) && (hi_en || lo_en)) begin
                if (op_sel == OpMults) begin
                    longint sa, sb;
                    sa = longint'(signed'(a));
                    sb = longint'(signed'(b));
                    m_prod = 64'(sa * sb);
                end else begin
                    m_prod = {32'b0, a} * {32'b0, b};
                end
                m_he  = hi_en;
                m_le  = lo_en;
                m_cnt = 33;
            end
        end
    end

    always @(negedge clk) begin
        logic [31:0] exp_res;
        exp_res = (alu_lo_hi == 2'b10) ? m_hi : (alu_lo_hi == 2'b01) ? m_lo : alu_result;
        check("busy", 32'(busy), 32'(m_cnt > 0));
        check("done", 32'(done), 32'(m_done));
        check("hi_out", hi_out, m_hi);
        check("lo_out", lo_out, m_lo);
        check("result_out", result_out, exp_res);
    end

    task automatic issue(input logic [4:0] op, input logic [31:0] ia, input logic [31:0] ib,
                         input logic he, input logic le, input bit now);
        if (!now) begin
            @(posedge clk); #1;
        end
        start = 1; op_sel = op; a = ia; b = ib; hi_en = he; lo_en = le;
        @(posedge clk); #1;
        start = 0; op_sel = OpAdd; a = $urandom; b = $urandom; hi_en = 0; lo_en = 0;
    endtask

    task automatic wait_done(output int bc, output int dc);
        bc = 0; dc = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (busy) bc++;
            if (done) begin
                dc = i;
                break;
            end
        end
    endtask

    task automatic mul_check(string name, input logic [4:0] op, input logic [31:0] ia,
                             input logic [31:0] ib, input logic [31:0] ehi,
                             input logic [31:0] elo, input bit now);
        int bc, dc;
        issue(op, ia, ib, 1'b1, 1'b1, now);
        wait_done(bc, dc);
        check({name, "_busy_cycles"}, 32'(bc), 32'd33);
        check({name, "_done_cycle"}, 32'(dc), 32'd34);
        check({name, "_hi"}, hi_out, ehi);
        check({name, "_lo"}, lo_out, elo);
    endtask

    initial begin
        int bc, dc, nd, nb;
        rst_n = 0; start = 0; op_sel = 0; hi_en = 0; lo_en = 0;
        alu_lo_hi = 0; a = 0; b = 0; alu_result = 0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_hi", hi_out, 32'd0);
        check("reset_lo", lo_out, 32'd0);
        rst_n = 1;

        // Abort mid-multiply with reset
        issue(OpMultu, 32'd7, 32'd9, 1'b1, 1'b1, 1'b0);
        repeat (9) @(posedge clk);
        #1; rst_n = 0; #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_hi", hi_out, 32'd0);
        check("abort_lo", lo_out, 32'd0);
        @(posedge clk); #1; rst_n = 1;
        nd = 0; nb = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) nd++;
            if (busy) nb++;
        end
        check("abort_no_done", 32'(nd), 32'd0);
        check("abort_no_busy", 32'(nb), 32'd0);

        mul_check("multu_max", OpMultu, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                  32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
        #1; alu_lo_hi = 2'b10; #1;
        check("mux_hi", result_out, 32'hFFFF_FFFE);
        mul_check("mults_neg3x5", OpMults, 32'hFFFF_FFFD, 32'd5,
                  32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0);
        mul_check("multu_neg3x5", OpMultu, 32'hFFFF_FFFD, 32'd5,
                  32'h0000_0004, 32'hFFFF_FFF1, 1'b0);
        mul_check("mults_min_sq", OpMults, 32'h8000_0000, 32'h8000_0000,
                  32'h4000_0000, 32'h0000_0000, 1'b0);
        mul_check("mults_min_x1", OpMults, 32'h8000_0000, 32'd1,
                  32'hFFFF_FFFF, 32'h8000_0000, 1'b0);

        // Start while busy is ignored; operands scrambled mid-operation
        issue(OpMultu, 32'd3, 32'd5, 1'b1, 1'b1, 1'b0);
        repeat (5) @(posedge clk);
        #1; start = 1; op_sel = OpMultu; a = 32'd2; b = 32'd2; hi_en = 1; lo_en = 1;
        @(posedge clk); #1; start = 0; a = 32'd9; b = 32'd9;
        wait_done(bc, dc);
        check("ignore_done_seen", 32'(dc != 0), 32'd1);
        check("ignore_hi", hi_out, 32'd0);
        check("ignore_lo", lo_out, 32'd15);

        // Back-to-back accept in the done cycle
        mul_check("b2b_neg7x6", OpMults, 32'hFFFF_FFF9, 32'd6,
                  32'hFFFF_FFFF, 32'hFFFF_FFD6, 1'b1);

        // Non-multiply op passes alu_result through
        @(posedge clk); #1;
        start = 1; op_sel = OpAdd; hi_en = 1; lo_en = 1; a = 32'd5; b = 32'd5;
        alu_result = 32'h1234; alu_lo_hi = 2'b00;
        @(negedge clk);
        check("add_busy", 32'(busy), 32'd0);
        check("add_result", result_out, 32'h1234);
        @(posedge clk); #1; alu_lo_hi = 2'b01;
        @(negedge clk);
        check("add_busy2", 32'(busy), 32'd0);
        check("mux_lo", result_out, 32'hFFFF_FFD6);

        // Multiply with both enables low is not accepted
        @(posedge clk); #1; op_sel = OpMultu; hi_en = 0; lo_en = 0;
        repeat (2) @(posedge clk);
        #1; start = 0;
        check("noen_busy", 32'(busy), 32'd0);

        // HI-only write leaves LO untouched
        issue(OpMultu, 32'h0001_0000, 32'h0001_0000, 1'b1, 1'b0, 1'b0);
        wait_done(bc, dc);
        check("hionly_done_cycle", 32'(dc), 32'd34);
        check("hionly_hi", hi_out, 32'd1);
        check("hionly_lo", lo_out, 32'hFFFF_FFD6);

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

endmodule
